// File: rtl/qdr_burst2_responder_pkg.sv
// Shared constants and types for the QDR burst-of-2 responder.
package qdr_burst2_responder_pkg;

  localparam int QDR_BURST_LEN       = 2;
  localparam int QDR_LATENCY_DEFAULT = 12;
  localparam int QDR_LATENCY_MIN     = 2;
  localparam int QDR_LATENCY_MAX     = 64;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_BEAT1 = 1'b1
  } wr_state_e;

endpackage

// File: rtl/qdr_resp_rd_pipe.sv
// Read-return path: ce-gated delay line for {vld, line} followed by a 2-beat serializer.
module qdr_resp_rd_pipe
  import qdr_burst2_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = 36,
  parameter int QDR_LATENCY = QDR_LATENCY_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ce,
  input  logic                                vld_i,
  input  logic [QDR_BURST_LEN*DATA_WIDTH-1:0] line_i,
  output logic [DATA_WIDTH-1:0]               dout_o,
  output logic                                dout_vld_o
);

  localparam int LW     = QDR_BURST_LEN * DATA_WIDTH;
  // The BRAM output register and the serializer register account for two cycles.
  localparam int STAGES = QDR_LATENCY - 2;

  logic          stage_vld;
  logic [LW-1:0] stage_line;

  generate
    if (STAGES == 0) begin : g_direct
      assign stage_vld  = vld_i;
      assign stage_line = line_i;
    end else begin : g_delay
      logic          vld_q  [STAGES];
      logic [LW-1:0] line_q [STAGES];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) vld_q[i] <= 1'b0;
        end else if (ce) begin
          vld_q[0] <= vld_i;
          for (int i = 1; i < STAGES; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (ce) begin
          line_q[0] <= line_i;
          for (int i = 1; i < STAGES; i++) line_q[i] <= line_q[i-1];
        end
      end

      assign stage_vld  = vld_q[STAGES-1];
      assign stage_line = line_q[STAGES-1];
    end
  endgenerate

  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] odd_q;
  logic                  vld_q;
  logic                  beat1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      vld_q   <= 1'b0;
      beat1_q <= 1'b0;
    end else if (ce) begin
      if (stage_vld) begin
        dout_q  <= stage_line[DATA_WIDTH-1:0];
        odd_q   <= stage_line[LW-1:DATA_WIDTH];
        vld_q   <= 1'b1;
        beat1_q <= 1'b1;
      end else if (beat1_q) begin
        dout_q  <= odd_q;
        vld_q   <= 1'b1;
        beat1_q <= 1'b0;
      end else begin
        vld_q   <= 1'b0;
      end
    end
  end

  assign dout_o     = dout_q;
  assign dout_vld_o = vld_q;

endmodule

// File: rtl/qdr_burst2_responder.sv
// BRAM-backed burst-of-2 QDR SRAM responder with fixed read latency.
// Define QDR_RESP_ERR_EN to build the sticky protocol-error detector.
module qdr_burst2_responder
  import qdr_burst2_responder_pkg::*;
#(
  parameter int ADDR_BITS   = 11,
  parameter int DATA_WIDTH  = 36,
  parameter int QDR_LATENCY = QDR_LATENCY_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  qdr_we,
  input  logic                  qdr_re,
  input  logic [ADDR_BITS-1:0]  qdr_addr,
  input  logic [DATA_WIDTH-1:0] qdr_din,
  output logic [DATA_WIDTH-1:0] qdr_dout,
  output logic                  dout_vld,
  output logic                  err
);

  localparam int LW    = QDR_BURST_LEN * DATA_WIDTH;
  localparam int DEPTH = 2 ** ADDR_BITS;

  generate
    if (QDR_LATENCY < QDR_LATENCY_MIN || QDR_LATENCY > QDR_LATENCY_MAX) begin : g_bad_latency
      $error("QDR_LATENCY out of range");
    end
  endgenerate

  wr_state_e             state_q, state_d;
  logic                  wr_accept;
  logic                  wr_commit;
  logic [ADDR_BITS-1:0]  wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_even_q;
  logic                  rd_accept;
  logic                  rd_prev_q;
  logic                  rd_vld_q;
  logic [LW-1:0]         rd_line_q;
  logic [LW-1:0]         mem [DEPTH];

  // A second write command arriving during beat 1 is dropped.
  always_comb begin
    state_d   = state_q;
    wr_accept = 1'b0;
    wr_commit = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (qdr_we) begin
          wr_accept = 1'b1;
          state_d   = WR_BEAT1;
        end
      end
      WR_BEAT1: begin
        wr_commit = 1'b1;
        state_d   = WR_IDLE;
      end
      default: state_d = WR_IDLE;
    endcase
  end

  assign rd_accept = qdr_re && !rd_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WR_IDLE;
      rd_prev_q <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else if (ce) begin
      state_q   <= state_d;
      rd_prev_q <= rd_accept;
      rd_vld_q  <= rd_accept;
      if (wr_accept) begin
        wr_addr_q <= qdr_addr;
        wr_even_q <= qdr_din;
      end
    end
  end

  // Read-first BRAM: a read in the commit cycle still sees the old line.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (wr_commit && !rst) mem[wr_addr_q] <= {qdr_din, wr_even_q};
      rd_line_q <= mem[qdr_addr];
    end
  end

  qdr_resp_rd_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .QDR_LATENCY (QDR_LATENCY)
  ) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .vld_i      (rd_vld_q),
    .line_i     (rd_line_q),
    .dout_o     (qdr_dout),
    .dout_vld_o (dout_vld)
  );

`ifdef QDR_RESP_ERR_EN
  logic we_raw_q, re_raw_q, err_q;
  logic write_overrun, read_overrun, rd_wr_hazard;

  assign write_overrun = qdr_we && we_raw_q;
  assign read_overrun  = qdr_re && re_raw_q;
  assign rd_wr_hazard  = rd_accept && (state_q == WR_BEAT1) && (qdr_addr == wr_addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      we_raw_q <= 1'b0;
      re_raw_q <= 1'b0;
      err_q    <= 1'b0;
    end else if (ce) begin
      we_raw_q <= qdr_we;
      re_raw_q <= qdr_re;
      err_q    <= err_q | write_overrun | read_overrun | rd_wr_hazard;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
